periph_uart_tx: RTL
===================

// Module: periph_uart_tx
// PURPOSE
//   Serial transmitter on the hart's output-peripheral byte space. The hart stores DATA, then bumps SEQ.
//   The block sees SEQ change, queues DATA in a FIFO and shifts it out as 8N1 UART frames.
//   It echoes the accepted SEQ on ack_seq, which the top level maps into input-peripheral space.
// PARAMETERS
//   CLKS_PER_BIT  434  clock cycles per serial bit (>=2)
//   FIFO_DEPTH    8    entries in the byte FIFO (power of two, >=2)
// PORTS
//   clock       in   1   system clock
//   reset       in   1   synchronous, active-high
//   out_seq     in   8   request sequence byte, from output_peripherals_mem[0]
//   out_data    in   8   byte to send, from output_peripherals_mem[1]
//   ack_seq     out  8   last accepted sequence value, to input_peripherals_mem[0]
//   fifo_level  out  $clog2(FIFO_DEPTH+1)  bytes queued, excluding the byte being shifted; to input_peripherals_mem[1]
//   busy        out  1   1 while a frame is on the line or the FIFO is non-empty
//   tx          out  1   serial output, idle high
// BEHAVIOUR
//   Reset: tx=1, ack_seq=0, fifo_level=0, busy=0. Internal last_seq=0, FIFO pointers=0, state IDLE, baud_cnt=0, bit_idx=0.
//   Request: a request exists when out_seq != last_seq (combinational compare).
//   Push: on a request with FIFO not full, at that posedge:
//     - out_data is pushed.
//     - last_seq and ack_seq are loaded with out_seq.
//   Request while full:
//     - Not accepted; ack_seq and last_seq hold.
//     - Retried every cycle until space exists.
//     - Software must hold out_data until ack_seq == out_seq.
//   Acceptance rate: at most one push per cycle. If SEQ jumps by more than 1, it is still a single push.
//   SEQ wrap: 8'hFF -> 8'h00 is an ordinary change.
//   fullness: full/empty come from the registered count, taken before this cycle's pop.
//     - Simultaneous push and pop on a non-full FIFO: count unchanged.
//     - A pop does not unblock a push in the same cycle.
//   Pointers: wrap modulo FIFO_DEPTH.
//   FSM states: IDLE, START, DATA, STOP (PARITY with the option below).
//   IDLE:
//     - tx=1.
//     - If FIFO non-empty: pop the head into shift_reg, baud_cnt=0, go to START.
//     - Latency: push to tx falling is 2 edges when IDLE and empty (push, then pop).
//   START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
//   DATA:
//     - tx=shift_reg[0], LSB first.
//     - After CLKS_PER_BIT cycles: shift right, bit_idx+1.
//     - After bit 7, go to STOP.
//   STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
//   Back-to-back frames: IDLE lasts exactly 1 cycle, so frame period = 10*CLKS_PER_BIT+1.
//   Baud timing:
//     - baud_cnt counts 0..CLKS_PER_BIT-1 and clears on each bit transition.
//     - tx is registered and changes only on bit boundaries.
//   busy = (state != IDLE) || (fifo_level != 0).
//   Reset mid-frame: tx=1 on the next edge and the FIFO is flushed; the partial frame is not completed.
//     - last_seq returns to 0, so a nonzero out_seq after reset is a new request.
//     - Software resets SEQ to 0 at boot.
// CONFIGURATION
//   UART_TX_PARITY_EN defined:
//     - A PARITY state sits between DATA and STOP.
//     - tx = ^byte (even parity) for CLKS_PER_BIT cycles.
//     - Frame = 11*CLKS_PER_BIT; back-to-back period = 11*CLKS_PER_BIT+1.
//   Undefined: 8N1 only; no PARITY state exists.
// TESTING (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
//   1. Reset, out_seq=0 held 20 cycles -> tx=1, ack_seq=0, busy=0, fifo_level=0.
//   2. out_data=8'hA5, out_seq 0->1 -> ack_seq=1 next edge; tx falls one edge later.
//      tx then shows 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. busy=0 after 41 cycles.
//   3. Issue 6 requests (seq 1..6, data 8'h10..8'h15) while the line is busy:
//      - fifo_level saturates at 4 and ack_seq stalls at 5.
//      - seq 6 is accepted when the next pop frees a slot.
//      - tx emits 10..15 in order, with a 41-cycle frame period.
//   4. out_seq 8'hFF -> 8'h00 with last_seq=8'hFF -> one push, ack_seq=8'h00.
//   5. Assert reset at bit 3 of a frame with 2 bytes queued -> next edge: tx=1, fifo_level=0, busy=0.
//      No further frames until out_seq changes.
//   6. UART_TX_PARITY_EN defined, send 8'h07 -> parity bit 1 before stop; frame is 44 cycles.

Source files
------------

// File: rtl/periph_uart_tx.sv
// periph_uart_tx: UART transmitter for the hart's output-peripheral byte space.
// The hart writes a byte to out_data and then changes out_seq. Each change is
// accepted once, the byte is queued in a small FIFO, and bytes leave the FIFO
// as 8N1 frames on tx. The accepted sequence value is echoed on ack_seq.
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit.
module periph_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [7:0]                       out_seq,
    input  logic [7:0]                       out_data,
    output logic [7:0]                       ack_seq,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             busy,
    output logic                             tx
);

    localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
`endif

    logic [7:0]        lastSeq_q;
    logic [LVL_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [2:0]        state_q, state_d;
    logic [BAUD_W-1:0] baudCnt_q, baudCnt_d;
    logic [2:0]        bitIdx_q, bitIdx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic fifoFull;
    logic fifoEmpty;
    logic push;
    logic pop;
    logic bitEnd;

    // Fullness is judged on the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign fifoFull  = (count_q == LVL_W'(FIFO_DEPTH));
    assign fifoEmpty = (count_q == '0);
    assign push      = (out_seq != lastSeq_q) && !fifoFull;
    assign bitEnd    = (baudCnt_q == BAUD_W'(CLKS_PER_BIT - 1));

    assign ack_seq    = lastSeq_q;
    assign fifo_level = count_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign tx         = tx_q;

    // Remember the last accepted sequence value; it doubles as the acknowledge.
    always_ff @(posedge clock) begin
        if (reset) begin
            lastSeq_q <= 8'h00;
        end else if (push) begin
            lastSeq_q <= out_seq;
        end
    end

    // Byte storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wrPtr_q] <= out_data;
        end
    end

    // Occupancy follows push/pop; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Frame sequencer: tx is set together with each state change so the line
    // only moves on bit boundaries, and IDLE lasts a single cycle between frames.
    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q + BAUD_W'(1);
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                baudCnt_d = '0;
                tx_d      = 1'b1;
                if (!fifoEmpty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rdPtr_q];
                    state_d = START;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^mem_q[rdPtr_q];
`endif
                end
            end
            START: begin
                if (bitEnd) begin
                    state_d   = DATA;
                    baudCnt_d = '0;
                    bitIdx_d  = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (bitEnd) begin
                    baudCnt_d = '0;
                    if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d  = {1'b0, shift_q[7:1]};
                        bitIdx_d = bitIdx_q + 3'd1;
                        tx_d     = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bitEnd) begin
                    state_d   = STOP;
                    baudCnt_d = '0;
                    tx_d      = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bitEnd) begin
                    state_d   = IDLE;
                    baudCnt_d = '0;
                    tx_d      = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                baudCnt_d = '0;
                tx_d      = 1'b1;
            end
        endcase
    end

    // Sequencer registers; reset abandons any partial frame and idles the line.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule
